// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle ARMv4 main control sequencer
// Steps FETCH/DECODE/EXEC/MEM/WB and drives datapath selects, enables and ALUControl.
module multicycle_ctrl_fsm #(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       Illegal,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(WAIT_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic [3:0]       cmd;
  logic             is_cmp;
  logic [3:0]       alu_dp;
  logic [1:0]       flagw_dp;

  // Data-processing decode, shared by EXECR/EXECI/ALUWB
  always_comb begin
    cmd    = Funct[4:1];
    is_cmp = (cmd == 4'b1010);
    case (cmd)
      4'b0000:         alu_dp = 4'b0010;
      4'b1100:         alu_dp = 4'b0011;
      4'b0010, 4'b1010: alu_dp = 4'b0001;
      default:         alu_dp = 4'b0000;
    endcase
    flagw_dp = {Funct[0], Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | is_cmp)};
  end

  // A MemReady=1 in the limit cycle completes normally, so timeout needs MemReady low
  always_comb begin
    timeout = (WAIT_LIMIT != 0) && !MemReady
           && ((state == FETCH) || (state == MEMRD) || (state == MEMWR))
           && (({1'b0, wait_cnt} + 1'b1) == LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (MemReady)      state    <= DECODE;
          else if (!timeout) wait_cnt <= wait_cnt + 1'b1;
        end
        DECODE: begin
          case (Op)
            2'b00:   state <= Funct[5] ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD: begin
          if (MemReady)     state    <= MEMWB;
          else if (timeout) state    <= FETCH;
          else              wait_cnt <= wait_cnt + 1'b1;
        end
        MEMWR: begin
          if (MemReady || timeout) state    <= FETCH;
          else                     wait_cnt <= wait_cnt + 1'b1;
        end
        EXECR, EXECI: state <= ALUWB;
        default:      state <= FETCH;
      endcase
    end
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0000;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    Illegal    = 1'b0;
    Fault      = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        Fault     = timeout;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = (Op == 2'b11);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD: begin
        AdrSrc = 1'b1;
        Fault  = timeout;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = MemReady;
        Fault  = timeout;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dp;
        FlagW      = flagw_dp;
        NoWrite    = is_cmp;
      end
      ALUWB: begin
        RegW    = ~is_cmp;
        FlagW   = flagw_dp;
        NoWrite = is_cmp;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
    // Reset holds state at FETCH; strobes must not fire from that decode
    if (reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      Illegal = 1'b0;
      Fault   = 1'b0;
    end
  end

  always_comb begin
    PCS   = ((Rd == 4'd15) & (((Op == 2'b00) & ~is_cmp) | ((Op == 2'b01) & Funct[0])))
          | (Op == 2'b10);
    State = state;
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
  localparam int WL = 4;

  logic       clk, reset, MemReady;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, PCS, NoWrite, Illegal, Fault;
  logic [1:0] ALUSrcB, ResultSrc, FlagW;
  logic [3:0] ALUControl, State;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, npc, adr, srca;
    logic [1:0] srcb, res;
    logic [3:0] alu;
    logic       regw, memw, br, pcs;
    logic [1:0] flagw;
    logic       nowr, ill, flt;
  } obs_t;

  multicycle_ctrl_fsm #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .PCS(PCS), .FlagW(FlagW), .NoWrite(NoWrite), .Illegal(Illegal), .Fault(Fault), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = '0;
    o.st = State; o.irw = IRWrite; o.npc = NextPC; o.adr = AdrSrc; o.srca = ALUSrcA;
    o.srcb = ALUSrcB; o.res = ResultSrc; o.alu = ALUControl; o.regw = RegW; o.memw = MemW;
    o.br = Branch; o.pcs = PCS; o.flagw = FlagW; o.nowr = NoWrite; o.ill = Illegal; o.flt = Fault;
    return o;
  endfunction

  // Reference: expand one instruction into its expected cycle sequence, then drive and compare
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                           input int fst, input int mst, input string tag);
    obs_t q[$];
    bit   mq[$];
    obs_t o, a;
    logic [3:0] cmd;
    bit   cmp, writes, pcs_exp, alive;
    int   alu_op;
    cmd     = f[4:1];
    cmp     = (cmd == 4'd10);
    writes  = (op == 2'd0 && !cmp) || (op == 2'd1 && f[0]);
    pcs_exp = (rd == 4'd15 && writes) || op == 2'd2;
    alu_op  = (cmd == 4'd0) ? 2 : (cmd == 4'd12) ? 3 : (cmd == 4'd2 || cmd == 4'd10) ? 1 : 0;
    alive   = 1;
    for (int i = 0; i < fst; i++) begin
      o = '0; o.st = 0; o.srca = 1; o.srcb = 2; o.res = 2; o.flt = (i == WL - 1);
      q.push_back(o); mq.push_back(1'b0);
    end
    if (fst >= WL) alive = 0;
    if (alive) begin
      o = '0; o.st = 0; o.srca = 1; o.srcb = 2; o.res = 2; o.irw = 1; o.npc = 1;
      q.push_back(o); mq.push_back(1'b1);
      o = '0; o.st = 1; o.srca = 1; o.srcb = 2; o.res = 2; o.ill = (op == 2'd3);
      q.push_back(o); mq.push_back(1'($urandom));
      if (op == 2'd0) begin
        o = '0; o.st = f[5] ? 7 : 6; o.srcb = f[5] ? 2'd1 : 2'd0; o.alu = 4'(alu_op);
        o.flagw = {f[0], f[0] & (cmd == 4'd4 || cmd == 4'd2 || cmp)}; o.nowr = cmp;
        q.push_back(o); mq.push_back(1'($urandom));
        o.st = 8; o.srcb = 0; o.alu = 0; o.regw = !cmp;
        q.push_back(o); mq.push_back(1'($urandom));
      end else if (op == 2'd1) begin
        o = '0; o.st = 2; o.srcb = 1;
        q.push_back(o); mq.push_back(1'($urandom));
        for (int i = 0; i < mst; i++) begin
          o = '0; o.st = f[0] ? 3 : 5; o.adr = 1; o.flt = (i == WL - 1);
          q.push_back(o); mq.push_back(1'b0);
        end
        if (mst < WL) begin
          o = '0; o.st = f[0] ? 3 : 5; o.adr = 1; o.memw = !f[0];
          q.push_back(o); mq.push_back(1'b1);
          if (f[0]) begin
            o = '0; o.st = 4; o.res = 1; o.regw = 1;
            q.push_back(o); mq.push_back(1'($urandom));
          end
        end
      end else if (op == 2'd2) begin
        o = '0; o.st = 9; o.srcb = 1; o.res = 2; o.br = 1;
        q.push_back(o); mq.push_back(1'($urandom));
      end
    end
    Op = op; Funct = f; Rd = rd;
    for (int c = 0; c < q.size(); c++) begin
      o = q[c]; o.pcs = pcs_exp;
      MemReady = mq[c];
      #1;
      a = sample();
      checks++;
      if (a !== o) begin
        failures++;
        $display("FAIL %s cyc%0d op=%0d f=%b got=%h exp=%h", tag, c, op, f, a, o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    obs_t a;
    reset = 1'b1; MemReady = 1'b1; Op = 2'd3; Funct = '0; Rd = '0;
    @(negedge clk); #1;
    a = sample();
    checks++;
    if (a.st !== 4'd0 || a.irw !== 1'b0 || a.npc !== 1'b0 || a.ill !== 1'b0 || a.flt !== 1'b0
        || a.regw !== 1'b0 || a.memw !== 1'b0 || a.br !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h", a);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();   run_instr(2'd0, 6'b001000, 4'd3, 0, 0, "add_reg");   endtask
  task automatic test_cmp();   run_instr(2'd0, 6'b110101, 4'd15, 0, 0, "cmp_imm"); endtask
  task automatic test_ldr();   run_instr(2'd1, 6'b011001, 4'd15, 1, 3, "ldr_stall"); endtask
  task automatic test_str_timeout(); run_instr(2'd1, 6'b011000, 4'd2, 0, WL, "str_timeout"); endtask
  task automatic test_fetch_timeout(); run_instr(2'd0, 6'b001000, 4'd1, WL, 0, "fetch_timeout"); endtask

  task automatic test_branch_illegal();
    run_instr(2'd2, 6'b000000, 4'd0, 0, 0, "branch");
    run_instr(2'd3, 6'b101010, 4'd15, 0, 0, "illegal");
  endtask

  task automatic test_back_to_back();
    int r1, r2;
    for (int n = 0; n < 60; n++) begin
      r1 = $urandom_range(0, 9);
      r2 = $urandom_range(0, 9);
      run_instr(2'($urandom), 6'($urandom), 4'($urandom_range(13, 15)),
                (r1 < 5) ? 0 : r1 - 5, (r2 < 5) ? 0 : r2 - 5, "random");
    end
  endtask

  task automatic test_reset_mid();
    Op = 2'd1; Funct = 6'b011000; Rd = 4'd4;
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1; #1;
      checks++;
      if (State !== 4'(i)) begin
        failures++;
        $display("FAIL reset_mid_walk got=%0d exp=%0d", State, i);
      end
      @(negedge clk);
    end
    MemReady = 1'b1; #1;
    checks++;
    if (State !== 4'd5 || MemW !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got st=%0d memw=%b exp st=5 memw=1", State, MemW);
    end
    #1 reset = 1'b1; #1;
    checks++;
    if (State !== 4'd0 || MemW !== 1'b0 || IRWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort got st=%0d memw=%b irw=%b exp 0 0 0", State, MemW, IRWrite);
    end
    @(negedge clk); #1;
    checks++;
    if (State !== 4'd0 || MemW !== 1'b0 || NextPC !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold got st=%0d memw=%b npc=%b exp 0 0 0", State, MemW, NextPC);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_ldr();
    test_str_timeout();
    test_fetch_timeout();
    test_branch_illegal();
    test_back_to_back();
    test_reset_mid();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
